// File: rtl/pc_fetch_if.sv
// Fetch-side bundle between the PC fetch controller and its neighbours:
// ADD4 incrementer, redirect source, hazard unit and instruction memory.
interface pc_fetch_if;
   logic [31:0] pc;
   logic [31:0] seq_pc;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        stall;
   logic        imem_req;
   logic        imem_ready;
   logic        if_valid;
   logic [31:0] if_pc;

   // Fetch controller side
   modport master (
      output pc,
      output imem_req,
      output if_valid,
      output if_pc,
      input  seq_pc,
      input  branch_taken,
      input  branch_target,
      input  stall,
      input  imem_ready
   );

   // Environment side (incrementer, pipeline, instruction memory)
   modport slave (
      input  pc,
      input  imem_req,
      input  if_valid,
      input  if_pc,
      output seq_pc,
      output branch_taken,
      output branch_target,
      output stall,
      output imem_ready
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: sequences fetch requests to instruction memory,
// applies branch redirects (buffering one that arrives while memory is
// busy), squashes wrong-path fetches and reports completed fetches.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst,
   pc_fetch_if.master fif
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t      state_q, state_nxt;
   logic [31:0] pc_q, pc_nxt;
   logic [31:0] redir_q, redir_nxt;
   logic        pend_q, pend_nxt;
   logic        if_vld_p1, if_vld_nxt;
   logic [31:0] if_pc_p1, if_pc_nxt;
   logic        imem_req;
   logic        accept;

   // Next-state, next-pc, redirect buffer and completion reporting
   always_comb begin
      state_nxt  = state_q;
      pc_nxt     = pc_q;
      redir_nxt  = redir_q;
      pend_nxt   = pend_q;
      if_vld_nxt = 1'b0;
      if_pc_nxt  = if_pc_p1;
      imem_req   = 1'b0;
      accept     = 1'b0;
      case (state_q)
         BOOT: begin
            pc_nxt    = RESET_PC;
            state_nxt = fif.stall ? STALL : REQ;
         end
         REQ: begin
            // Request stays up and pc stays put until memory accepts;
            // stall only matters once the fetch has been taken.
            imem_req = 1'b1;
            accept   = fif.imem_ready;
            if (accept) begin
               if (fif.branch_taken)
                  pc_nxt = fif.branch_target;
               else if (pend_q)
                  pc_nxt = redir_q;
               else
                  pc_nxt = fif.seq_pc;
               pend_nxt = 1'b0;
               // A redirect seen in the acceptance cycle means this fetch
               // was on the wrong path.
               if_vld_nxt = !(fif.branch_taken || pend_q);
               if (!(fif.branch_taken || pend_q))
                  if_pc_nxt = pc_q;
               state_nxt = fif.stall ? STALL : REQ;
            end else if (fif.branch_taken) begin
               redir_nxt = fif.branch_target;
               pend_nxt  = 1'b1;
            end
         end
         STALL: begin
            if (fif.branch_taken)
               pc_nxt = fif.branch_target;
            if (!fif.stall)
               state_nxt = REQ;
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   // State and datapath registers; reset abandons any outstanding request
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         redir_q   <= 32'h0;
         pend_q    <= 1'b0;
         if_vld_p1 <= 1'b0;
         if_pc_p1  <= 32'h0;
      end else begin
         state_q   <= state_nxt;
         pc_q      <= pc_nxt;
         redir_q   <= redir_nxt;
         pend_q    <= pend_nxt;
         if_vld_p1 <= if_vld_nxt;
         if_pc_p1  <= if_pc_nxt;
      end
   end

   assign fif.pc       = pc_q;
   assign fif.imem_req = imem_req;
   assign fif.if_valid = if_vld_p1;
   assign fif.if_pc    = if_pc_p1;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with an ideal ADD4 (seq_pc = pc + 1).
module tb_pc_fetch_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pc_fetch_if fif ();

   pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .fif (fif)
   );

   // ADD4 incrementer model, wraps naturally at 32 bits
   assign fif.seq_pc = fif.pc + 32'd1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expect pc, imem_req, if_valid and (when valid) if_pc
   task automatic expect_st(input string tag, input logic [31:0] pc, input logic req,
                            input logic vld, input logic [31:0] ifpc);
      check({tag, ".pc"},       fif.pc,       pc);
      check({tag, ".imem_req"}, {31'b0, fif.imem_req}, {31'b0, req});
      check({tag, ".if_valid"}, {31'b0, fif.if_valid}, {31'b0, vld});
      check({tag, ".if_pc"},    fif.if_pc,    ifpc);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      fif.branch_taken  = 1'b0;
      fif.branch_target = 32'h0;
      fif.stall         = 1'b0;
      fif.imem_ready    = 1'b1;
      step();
      step();
      expect_st("reset", 32'h0, 1'b0, 1'b0, 32'h0);

      // Back-to-back sequential fetch from reset
      rst = 1'b0;
      step();
      expect_st("boot_exit", 32'h0, 1'b1, 1'b0, 32'h0);
      step();
      expect_st("seq1", 32'h1, 1'b1, 1'b1, 32'h0);
      step();
      expect_st("seq2", 32'h2, 1'b1, 1'b1, 32'h1);
      step();
      expect_st("seq3", 32'h3, 1'b1, 1'b1, 32'h2);

      // Accept pc=3 with stall, redirect during stall, resume
      fif.stall = 1'b1;
      step();
      expect_st("stall_in", 32'h4, 1'b0, 1'b1, 32'h3);
      step();
      expect_st("stall_hold", 32'h4, 1'b0, 1'b0, 32'h3);
      fif.branch_taken  = 1'b1;
      fif.branch_target = 32'h20;
      step();
      expect_st("stall_br", 32'h20, 1'b0, 1'b0, 32'h3);
      fif.branch_taken = 1'b0;
      fif.stall        = 1'b0;
      step();
      expect_st("stall_out", 32'h20, 1'b1, 1'b0, 32'h3);
      step();
      expect_st("resume", 32'h21, 1'b1, 1'b1, 32'h20);

      // Reset and run to pc=5, then memory not ready for 3 cycles
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      for (int i = 0; i < 5; i++) step();
      expect_st("at5", 32'h5, 1'b1, 1'b1, 32'h4);
      fif.imem_ready = 1'b0;
      fif.stall      = 1'b1;
      step();
      expect_st("wait1", 32'h5, 1'b1, 1'b0, 32'h4);
      fif.stall = 1'b0;
      step();
      expect_st("wait2", 32'h5, 1'b1, 1'b0, 32'h4);
      step();
      expect_st("wait3", 32'h5, 1'b1, 1'b0, 32'h4);
      fif.imem_ready = 1'b1;
      step();
      expect_st("wait_done", 32'h6, 1'b1, 1'b1, 32'h5);
      step();
      step();
      expect_st("at8", 32'h8, 1'b1, 1'b1, 32'h7);

      // Redirect while memory busy: buffered, fetch of 8 squashed
      fif.imem_ready    = 1'b0;
      fif.branch_taken  = 1'b1;
      fif.branch_target = 32'h40;
      step();
      expect_st("pend_set", 32'h8, 1'b1, 1'b0, 32'h7);
      fif.branch_taken = 1'b0;
      step();
      expect_st("pend_hold", 32'h8, 1'b1, 1'b0, 32'h7);
      fif.imem_ready = 1'b1;
      step();
      expect_st("squash8", 32'h40, 1'b1, 1'b0, 32'h7);
      step();
      expect_st("tgt40", 32'h41, 1'b1, 1'b1, 32'h40);
      step();
      expect_st("tgt41", 32'h42, 1'b1, 1'b1, 32'h41);

      // Later redirect overwrites the buffered one
      fif.imem_ready    = 1'b0;
      fif.branch_taken  = 1'b1;
      fif.branch_target = 32'h80;
      step();
      fif.branch_target = 32'h90;
      step();
      fif.branch_taken = 1'b0;
      fif.imem_ready   = 1'b1;
      step();
      expect_st("overwrite", 32'h90, 1'b1, 1'b0, 32'h41);

      // Wrap of the address space through seq_pc
      fif.branch_taken  = 1'b1;
      fif.branch_target = 32'hFFFF_FFFF;
      step();
      expect_st("to_max", 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h41);
      fif.branch_taken = 1'b0;
      step();
      expect_st("wrap", 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);

      // Reset over a pending redirect with branch and stall also asserted
      fif.imem_ready    = 1'b0;
      fif.branch_taken  = 1'b1;
      fif.branch_target = 32'h100;
      step();
      rst               = 1'b1;
      fif.branch_target = 32'h200;
      fif.stall         = 1'b1;
      step();
      expect_st("rst_over", 32'h0, 1'b0, 1'b0, 32'h0);
      rst              = 1'b0;
      fif.branch_taken = 1'b0;
      fif.stall        = 1'b0;
      fif.imem_ready   = 1'b1;
      step();
      expect_st("rst_boot", 32'h0, 1'b1, 1'b0, 32'h0);
      step();
      expect_st("pend_clr", 32'h1, 1'b1, 1'b1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pc  output  32  current fetch address; drives the ADD4 incrementer's current_address and the instruction-memory address.
REQ-005 seq_pc  input  32  sequential next address from ADD4 next_address (pc + 1, word-addressed).
REQ-006 branch_taken  input  1  redirect request from a later stage, valid for one cycle.
REQ-007 branch_target  input  32  redirect address, sampled when branch_taken=1.
REQ-008 stall  input  1  downstream hazard stall; blocks new fetch requests.
REQ-009 imem_req  output  1  fetch request valid to instruction memory.
REQ-010 imem_ready  input  1  memory accepts the request this cycle.
REQ-011 if_valid  output  1  one-cycle pulse: fetch for if_pc completed and not squashed.
REQ-012 if_pc  output  32  address of the fetch reported by if_valid.

Function
REQ-013 States SHALL be BOOT, REQ and STALL. Fetch acceptance is the cycle with imem_req=1 and imem_ready=1.
REQ-014 BOOT: imem_req=0, pc=RESET_PC; next state is REQ if stall=0, else STALL.
REQ-015 REQ: imem_req=1; while imem_ready=0, pc SHALL stay stable and imem_req SHALL stay high (no withdrawal, stall ignored).
REQ-016 REQ, on acceptance: pc loads branch_target if branch_taken=1; else the pending-redirect address if pending; else seq_pc. Next state is STALL if stall=1, else REQ.
REQ-017 REQ, branch_taken=1 without acceptance: latch branch_target into a one-entry redirect buffer and set pending; a later branch_taken before acceptance overwrites the buffer.
REQ-018 The pending flag SHALL clear on the acceptance that consumes it.
REQ-019 STALL: imem_req=0; pc held unless branch_taken=1, in which case pc loads branch_target on the next edge. Leave to REQ when stall=0.
REQ-020 Redirect priority SHALL be: rst > branch_taken > pending redirect > seq_pc.
REQ-021 Squash: an accepted fetch is squashed if, in its acceptance cycle, branch_taken=1 or pending=1.
REQ-022 For each non-squashed acceptance, if_valid=1 and if_pc = the accepted pc on the next cycle only; otherwise if_valid=0. if_pc holds its last value while if_valid=0.
REQ-023 Address arithmetic is 32-bit, no carry. Wrap from 32'hFFFF_FFFF to 0 comes from seq_pc and SHALL be accepted unmodified.
REQ-024 Back-to-back acceptances (imem_ready=1 continuously, stall=0) SHALL give one fetch per cycle with no bubble.

Reset
REQ-025 While rst=1 at a rising edge: state=BOOT, pc=RESET_PC, imem_req=0, if_valid=0, if_pc=32'h0, pending=0, redirect buffer=0.
REQ-026 rst asserted mid-request (imem_req=1, imem_ready=0) SHALL abandon the request; no if_valid for it.
REQ-027 rst SHALL override branch_taken and stall in the same cycle.

Verification
REQ-028 Reset release, stall=0, imem_ready=1 every cycle: pc = 0,1,2,3; if_valid high from the third cycle with if_pc = 0,1,2.
REQ-029 At pc=5, imem_ready low for 3 cycles, then high: pc held at 5 and imem_req high throughout; exactly one if_valid, with if_pc=5.
REQ-030 At pc=8, branch_taken=1 with target 32'h40 while imem_ready=0, imem_ready=1 two cycles later: fetch of 8 squashed (no if_valid); next pc=32'h40, then 32'h41 reported valid.
REQ-031 Accepted fetch of pc=3 with stall=1: STALL, imem_req=0, pc=4 held; branch_taken target 32'h20 during stall gives pc=32'h20; stall=0 resumes fetch at 32'h20.
REQ-032 pc=32'hFFFF_FFFF, seq_pc=0, imem_ready=1: next pc=32'h0, if_valid with if_pc=32'hFFFF_FFFF.
REQ-033 rst=1 during pending redirect and branch_taken=1: pc=RESET_PC, pending cleared, no if_valid in the following cycle.
